// File: rtl/gba_audio_pkg.sv
// Shared types and frame constants for the GBA audio path (mixer to I2S codec).
package gba_audio_pkg;

    localparam int unsigned I2S_SLOT_BITS    = 32;
    localparam int unsigned I2S_FRAME_BITS   = 64;
    localparam int unsigned I2S_SAMPLE_MAX_W = I2S_SLOT_BITS - 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_tx_state_t;

    // Samples are stored MSB-justified in the widest width a slot can carry.
    typedef struct packed {
        logic [I2S_SAMPLE_MAX_W-1:0] l;
        logic [I2S_SAMPLE_MAX_W-1:0] r;
    } stereo_sample_t;

endpackage

// File: rtl/audio_clk_div.sv
// Half-period counter: toggles `level` every HALF_DIV cycles; `clear` holds it at phase 0.
module audio_clk_div #(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic clk_100,
    input  logic reset,
    input  logic clear,
    output logic tick_c,
    output logic level
);

    localparam int unsigned CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Strobe on the last cycle of a half-period; the level flips on the following edge.
    assign tick_c = !clear && (cnt == CNT_MAX);

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (tick_c) begin
            cnt   <= '0;
            level <= !level;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/gba_i2s_tx.sv
// Philips I2S master transmitter for the GBA mixer output; requests one stereo sample per frame.
// Build option GBA_I2S_TX_UNDERRUN_ZERO_EN: a stale frame load transmits silence instead of repeating.
module gba_i2s_tx
    import gba_audio_pkg::*;
#(
    parameter int unsigned MCLK_HALF_DIV = 4,
    parameter int unsigned BCLK_HALF_DIV = 16,
    parameter int unsigned SAMPLE_W      = 24
) (
    input  logic                clk_100,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                new_sample,
    output logic                ac_mclk,
    output logic                ac_bclk,
    output logic                ac_lrclk,
    output logic                ac_sdata,
    output logic                underrun,
    output logic [15:0]         underrun_cnt
);

    localparam int unsigned BIT_CNT_W  = $clog2(I2S_FRAME_BITS);
    localparam int unsigned SLOT_IDX_W = $clog2(I2S_SLOT_BITS);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(I2S_FRAME_BITS - 1);
    localparam logic [SLOT_IDX_W-1:0] SLOT_TOP = SLOT_IDX_W'(I2S_SLOT_BITS - 1);

    i2s_tx_state_t          state;
    i2s_tx_state_t          state_n;
    logic                   load_c;
    logic                   stale_c;
    logic                   bclk_tick_c;
    logic                   bclk_fall_c;
    logic                   unused_mclk_tick_c;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [BIT_CNT_W-1:0]   next_bit;
    logic [I2S_SLOT_BITS-1:0] slot_word;
    logic                   sdata_n;
    logic                   fresh;
    stereo_sample_t         hold;
    stereo_sample_t         frame;

    function automatic logic [I2S_SAMPLE_MAX_W-1:0] justify(input logic [SAMPLE_W-1:0] s);
        return I2S_SAMPLE_MAX_W'(s) << (I2S_SAMPLE_MAX_W - SAMPLE_W);
    endfunction

    audio_clk_div #(.HALF_DIV(MCLK_HALF_DIV)) u_mclk_div (
        .clk_100 (clk_100),
        .reset   (reset),
        .clear   (1'b0),
        .tick_c  (unused_mclk_tick_c),
        .level   (ac_mclk)
    );

    // Bit clock is parked at phase 0 while idle so every frame starts with a full low half.
    audio_clk_div #(.HALF_DIV(BCLK_HALF_DIV)) u_bclk_div (
        .clk_100 (clk_100),
        .reset   (reset),
        .clear   (state == IDLE),
        .tick_c  (bclk_tick_c),
        .level   (ac_bclk)
    );

    assign bclk_fall_c = bclk_tick_c && ac_bclk;

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and frame-load decision; enable is only honoured at frame boundaries.
    always_comb begin
        state_n = state;
        load_c  = 1'b0;
        stale_c = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = RUN;
                    load_c  = 1'b1;
                end
            end
            RUN: begin
                if (bclk_fall_c && (bit_cnt == LAST_BIT)) begin
                    if (enable) begin
                        load_c  = 1'b1;
                        stale_c = !fresh;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Slot bit 0 is the I2S one-bit delay; the MSB-justified sample fills the slot after it.
    always_comb begin
        next_bit  = bit_cnt + BIT_CNT_W'(1);
        slot_word = {1'b0, next_bit[BIT_CNT_W-1] ? frame.r : frame.l};
        sdata_n   = slot_word[SLOT_TOP - next_bit[SLOT_IDX_W-1:0]];
    end

    // A capture coinciding with a load is kept for the next frame.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            hold  <= '0;
            fresh <= 1'b0;
        end else if (sample_valid) begin
            hold.l <= justify(sample_l);
            hold.r <= justify(sample_r);
            fresh  <= 1'b1;
        end else if (load_c) begin
            fresh <= 1'b0;
        end
    end

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            frame <= '0;
        end else if (load_c) begin
`ifdef GBA_I2S_TX_UNDERRUN_ZERO_EN
            frame <= stale_c ? '0 : hold;
`else
            frame <= hold;
`endif
        end
    end

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            bit_cnt      <= '0;
            ac_lrclk     <= 1'b0;
            ac_sdata     <= 1'b0;
            new_sample   <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            new_sample <= load_c;
            underrun   <= stale_c;
            if (stale_c && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
            if (load_c || (state_n == IDLE)) begin
                bit_cnt  <= '0;
                ac_lrclk <= 1'b0;
                ac_sdata <= 1'b0;
            end else if (bclk_fall_c) begin
                bit_cnt  <= next_bit;
                ac_lrclk <= next_bit[BIT_CNT_W-1];
                ac_sdata <= sdata_n;
            end
        end
    end

endmodule

// File: tb/tb_gba_i2s_tx.sv
// Scoreboard bench for gba_i2s_tx: stimulus queues expected frames, a monitor deserialises and checks them.
module tb_gba_i2s_tx;

    logic        clk_100 = 1'b0;
    logic        reset;
    logic        enable;
    logic [23:0] sample_l;
    logic [23:0] sample_r;
    logic        sample_valid;
    logic        new_sample;
    logic        ac_mclk;
    logic        ac_bclk;
    logic        ac_lrclk;
    logic        ac_sdata;
    logic        underrun;
    logic [15:0] underrun_cnt;

    int    total = 0;
    int    bad   = 0;
    longint cyc  = 0;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        ur;
        logic [15:0] cnt;
        bit          gap;
    } exp_t;

    exp_t sb[$];

    gba_i2s_tx dut (
        .clk_100      (clk_100),
        .reset        (reset),
        .enable       (enable),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .new_sample   (new_sample),
        .ac_mclk      (ac_mclk),
        .ac_bclk      (ac_bclk),
        .ac_lrclk     (ac_lrclk),
        .ac_sdata     (ac_sdata),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk_100 = ~clk_100;
    always @(posedge clk_100) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push(input logic [23:0] l, input logic [23:0] r,
                                 input logic ur, input logic [15:0] cnt, input bit gap);
        exp_t e;
        e.l = l; e.r = r; e.ur = ur; e.cnt = cnt; e.gap = gap;
        sb.push_back(e);
    endfunction

    task automatic put_sample(input logic [23:0] l, input logic [23:0] r);
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        @(negedge clk_100);
        sample_valid = 1'b0;
    endtask

    task automatic wait_ns();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_100);
            if (new_sample) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL new_sample_timeout: got none within 3000 cycles expected a pulse");
        end
    endtask

    // Monitor: one scoreboard entry per new_sample, whole frame captured and checked.
    initial begin : monitor
        longint      last_ns;
        exp_t        e;
        logic [63:0] bits;
        logic [23:0] gl, gr;
        logic        pad, cur_sd, ur_seen;
        logic [15:0] cnt_seen;
        int          shape_err;
        bit          aborted, have_exp;
        longint      this_ns;
        last_ns = -1;
        forever begin
            @(negedge clk_100);
            if (new_sample && !reset) begin
                have_exp = (sb.size() != 0);
                if (have_exp) begin
                    e = sb.pop_front();
                end else begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got new_sample at cycle %0d expected none", cyc);
                end
                this_ns   = cyc;
                bits      = '0;
                shape_err = 0;
                aborted   = 1'b0;
                cur_sd    = 1'b0;
                ur_seen   = 1'b0;
                cnt_seen  = '0;
                for (int c = 0; c < 2048; c++) begin
                    if (c > 0) @(negedge clk_100);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c % 32 == 0)  cur_sd = ac_sdata;
                    if (c % 32 == 16) bits[c / 32] = ac_sdata;
                    if (ac_sdata !== cur_sd) shape_err++;
                    if (ac_bclk !== ((c % 32) >= 16)) shape_err++;
                    if (ac_lrclk !== (c >= 1024)) shape_err++;
                    if (new_sample !== (c == 0)) shape_err++;
                    if (c == 0) begin
                        ur_seen  = underrun;
                        cnt_seen = underrun_cnt;
                    end else if (underrun !== 1'b0) begin
                        shape_err++;
                    end
                end
                if (have_exp && !aborted) begin
                    for (int i = 0; i < 24; i++) begin
                        gl[23 - i] = bits[1 + i];
                        gr[23 - i] = bits[33 + i];
                    end
                    pad = bits[0] | (|bits[31:25]) | bits[32] | (|bits[63:57]);
                    chk("frame_l", gl, e.l);
                    chk("frame_r", gr, e.r);
                    chk("frame_pad", pad, 0);
                    chk("frame_shape", shape_err, 0);
                    chk("underrun_pulse", ur_seen, e.ur);
                    chk("underrun_cnt", cnt_seen, e.cnt);
                    if (e.gap) chk("new_sample_period", this_ns - last_ns, 2048);
                end
                last_ns = this_ns;
            end
        end
    end

    initial begin : stimulus
        logic   prev_mclk;
        longint rise0, rise1;
        int     first_dir, idle_err, ns_cnt, quiet_err;
        reset        = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_l     = '0;
        sample_r     = '0;
        repeat (3) @(posedge clk_100);
        @(negedge clk_100);
        chk("reset_outputs", {ac_mclk, ac_bclk, ac_lrclk, ac_sdata, new_sample, underrun, underrun_cnt}, 0);
        reset = 1'b0;

        // MCLK free-runs, bit-clock side stays quiet with enable low.
        prev_mclk = ac_mclk;
        rise0 = -1; rise1 = -1; first_dir = -1; idle_err = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_100);
            if (ac_mclk !== prev_mclk && first_dir < 0) first_dir = ac_mclk ? 1 : 0;
            if (ac_mclk && !prev_mclk) begin
                if (rise0 < 0) rise0 = cyc;
                else if (rise1 < 0) rise1 = cyc;
            end
            if (ac_bclk || ac_lrclk || ac_sdata || new_sample) idle_err++;
            prev_mclk = ac_mclk;
        end
        chk("mclk_first_edge_rising", first_dir, 1);
        chk("mclk_period", rise1 - rise0, 8);
        chk("idle_quiet", idle_err, 0);

        // Serialise P; no capture during the first frame so the second one is stale.
        put_sample(24'h800001, 24'h7FFFFE);
        push(24'h800001, 24'h7FFFFE, 1'b0, 16'd0, 1'b0);
        enable = 1'b1;
        wait_ns();
`ifdef GBA_I2S_TX_UNDERRUN_ZERO_EN
        push(24'h000000, 24'h000000, 1'b1, 16'd1, 1'b1);
`else
        push(24'h800001, 24'h7FFFFE, 1'b1, 16'd1, 1'b1);
`endif
        wait_ns();
        repeat (100) @(negedge clk_100);
        put_sample(24'hABCDEF, 24'h000F0F);
        push(24'hABCDEF, 24'h000F0F, 1'b0, 16'd1, 1'b1);
        wait_ns();

        // Fresh sample mid-frame, then a second capture on the very edge of the next load.
        repeat (100) @(negedge clk_100);
        put_sample(24'h00FF00, 24'hFF0000);
        push(24'h00FF00, 24'hFF0000, 1'b0, 16'd1, 1'b1);
        repeat (1946) @(posedge clk_100);
        #1;
        sample_l     = 24'h123456;
        sample_r     = 24'h654321;
        sample_valid = 1'b1;
        push(24'h123456, 24'h654321, 1'b0, 16'd1, 1'b1);
        @(posedge clk_100);
        #1;
        sample_valid = 1'b0;
        wait_ns();
        wait_ns();

        // Drop enable at bit 10 of this frame: it must finish, then go silent.
        repeat (325) @(negedge clk_100);
        enable    = 1'b0;
        ns_cnt    = 0;
        quiet_err = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_100);
            if (new_sample) ns_cnt++;
            if ((326 + i) >= 2048 && (ac_bclk || ac_lrclk || ac_sdata)) quiet_err++;
        end
        chk("disable_no_new_sample", ns_cnt, 0);
        chk("disable_quiet", quiet_err, 0);

        // Async reset in the middle of a frame.
        put_sample(24'h0F0F0F, 24'hF0F0F0);
        push(24'h0F0F0F, 24'hF0F0F0, 1'b0, 16'd1, 1'b0);
        enable = 1'b1;
        wait_ns();
        repeat (40 * 32 + 8) @(negedge clk_100);
        #2;
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        chk("async_reset_outputs", {ac_mclk, ac_bclk, ac_lrclk, ac_sdata, new_sample, underrun, underrun_cnt}, 0);
        repeat (4) @(negedge clk_100);
        reset = 1'b0;
        repeat (4) @(negedge clk_100);

        put_sample(24'h000001, 24'h400000);
        push(24'h000001, 24'h400000, 1'b0, 16'd0, 1'b0);
        enable = 1'b1;
        wait_ns();
        repeat (200) @(negedge clk_100);
        enable = 1'b0;
        repeat (2300) @(negedge clk_100);
        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
